bram_port_arbiter: RTL

Round-robin arbiter that shares one port of the single-clock true-dual-port block RAM between NUM_REQ independent requesters. Each request is accepted with a per-requester valid/ready handshake and issued as a one-cycle RAM access. The read result is routed back to the issuing requester after the RAM's fixed read latency. It sits between the rasteriser/framebuffer clients and one RAM port; a second instance may own the other port.

---
 rtl/bram_port_arbiter_if.sv | 36 +++
 rtl/bram_port_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter_if.sv
// Signal bundle between NUM_REQ requesters, the arbiter and one block-RAM port.
// A request transfers in a cycle where req_valid[i] && req_ready[i]; the requester keeps
// req_we/req_addr/req_wdata stable while req_valid is high and may drop req_valid before
// the transfer at no cost. rsp_valid is a one-cycle pulse; rsp_data is qualified by it.
interface bram_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 18
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      ram_en;
    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_din;
    logic                      ram_regce;
    logic                      ram_rst;
    logic [DATA_W-1:0]         ram_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_dout,
        output req_ready, rsp_valid, rsp_data,
        output ram_en, ram_we, ram_addr, ram_din, ram_regce, ram_rst
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_dout,
        input  req_ready, rsp_valid, rsp_data,
        input  ram_en, ram_we, ram_addr, ram_din, ram_regce, ram_rst
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port among NUM_REQ requesters, with read-response
// routing. Define BRAM_ARB_PRIO0_EN to give requester 0 absolute priority over the others.
module bram_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 18,
    parameter int READ_LATENCY = 2,
    localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clka,
    input  logic               rsta,
    bram_port_arbiter_if.slave bus,
    output logic [IDX_W-1:0]   dbg_last_grant_o
);

    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [IDX_W-1:0]        grant_idx, cand_idx;
    logic [NUM_REQ-1:0]      grant_oh;
    logic                    grant_found;
    logic                    accept;

    logic                    ram_en_q, ram_en_d;
    logic                    ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]       ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]       ram_din_q, ram_din_d;
    logic [IDX_W-1:0]        issue_id_q, issue_id_d;

    logic [READ_LATENCY-1:0] pipe_v_q, pipe_v_d;
    logic [IDX_W-1:0]        pipe_id_q [READ_LATENCY];
    logic [IDX_W-1:0]        pipe_id_d [READ_LATENCY];
    logic                    rsp_fire;
    logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;

    // Scan from the requester after last_grant_q; the first valid one wins.
    always_comb begin : grant_select
        grant_idx   = '0;
        cand_idx    = '0;
        grant_found = 1'b0;
`ifdef BRAM_ARB_PRIO0_EN
        if (bus.req_valid[0]) begin
            grant_found = 1'b1;
        end
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
`ifdef BRAM_ARB_PRIO0_EN
            if (!grant_found && (cand_idx != '0) && bus.req_valid[cand_idx]) begin
`else
            if (!grant_found && bus.req_valid[cand_idx]) begin
`endif
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        grant_oh = '0;
        if (grant_found) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign accept        = grant_found && !rsta;
    assign bus.req_ready = accept ? grant_oh : '0;

    always_comb begin : next_state
        last_grant_d = accept ? grant_idx : last_grant_q;
        ram_en_d     = accept;
        ram_we_d     = accept && bus.req_we[grant_idx];
        ram_addr_d   = accept ? bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W] : ram_addr_q;
        ram_din_d    = accept ? bus.req_wdata[int'(grant_idx)*DATA_W +: DATA_W] : ram_din_q;
        issue_id_d   = accept ? grant_idx : issue_id_q;
        // Only reads enter the response pipe; writes complete silently.
        pipe_v_d[0]  = ram_en_q && !ram_we_q;
        pipe_id_d[0] = issue_id_q;
        for (int j = 1; j < READ_LATENCY; j++) begin
            pipe_v_d[j]  = pipe_v_q[j-1];
            pipe_id_d[j] = pipe_id_q[j-1];
        end
        rsp_data_d   = rsp_fire ? bus.ram_dout : rsp_data_q;
    end

    always_ff @(posedge clka or posedge rsta) begin : state_regs
        if (rsta) begin
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            issue_id_q   <= '0;
            pipe_v_q     <= '0;
            for (int j = 0; j < READ_LATENCY; j++) begin
                pipe_id_q[j] <= '0;
            end
            rsp_data_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            issue_id_q   <= issue_id_d;
            pipe_v_q     <= pipe_v_d;
            for (int j = 0; j < READ_LATENCY; j++) begin
                pipe_id_q[j] <= pipe_id_d[j];
            end
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rsp_fire = pipe_v_q[READ_LATENCY-1];

    always_comb begin : outputs
        bus.rsp_valid = '0;
        if (rsp_fire) begin
            bus.rsp_valid[pipe_id_q[READ_LATENCY-1]] = 1'b1;
        end
    end

    // rsp_data passes the RAM output through in the response cycle and holds it afterwards.
    assign bus.rsp_data      = rsp_data_d;
    assign bus.ram_en        = ram_en_q;
    assign bus.ram_we        = ram_we_q;
    assign bus.ram_addr      = ram_addr_q;
    assign bus.ram_din       = ram_din_q;
    assign bus.ram_regce     = 1'b1;
    assign bus.ram_rst       = rsta;
    assign dbg_last_grant_o  = last_grant_q;

endmodule
